// File: rtl/isa_types.sv
// isa_types: shared ISA-level types for the hart.
//   - opcode_t      : decoded opcode class produced by the instruction decoder
//   - hart_state_t  : hart_sequencer FSM states
//   - trap_cause_t  : sticky trap cause reported by the sequencer
//   - wb_sel_t      : register-file write-back source select
//   - MEM_SIZE_*    : memory access size encoding (matches funct3[1:0] of loads/stores)
package isa_types;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ILEN      = 32;
    localparam int unsigned TIMEOUT_W = 16;

    typedef enum logic [2:0] {
        OPCODE_UNKNOWN,
        OPCODE_LUI,
        OPCODE_OP,
        OPCODE_OP_IMM,
        OPCODE_LOAD,
        OPCODE_STORE
    } opcode_t;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWriteback,
        StTrap
    } hart_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE,
        TRAP_ILLEGAL,
        TRAP_MISALIGNED,
        TRAP_TIMEOUT
    } trap_cause_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_UIMM
    } wb_sel_t;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    // LB, LH, LW, LBU, LHU
    function automatic logic load_funct3_ok(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    // SB, SH, SW
    function automatic logic store_funct3_ok(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_SIZE_H: bad = addr_lo[0];
            MEM_SIZE_W: bad = |addr_lo;
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/hart_sequencer_if.sv
// hart_sequencer_if: single shared memory port of the hart.
//   mem_req   : request valid (master -> slave)
//   mem_addr  : request address
//   mem_we    : 1 = store
//   mem_size  : 0 = byte, 1 = half, 2 = word
//   mem_ready : request accepted/completed this cycle (slave -> master)
//   mem_rdata : read data, valid when mem_ready = 1
interface hart_sequencer_if;
    import isa_types::*;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [1:0]      mem_size;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_size,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_size,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: counts wait cycles of an outstanding bus request.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : reset the count to zero (no request, or handshake)
//   en_i       : increment (request pending, not ready)
//   limit_i    : expiry threshold; 0 disables expiry
//   expired_o  : count has reached limit_i
module bus_timeout_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [Width-1:0] limit_i,
    output logic             expired_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            // Saturate so a disabled limit never wraps back through small values.
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (limit_i != '0) && (count_q == limit_i);

endmodule

// File: rtl/hart_sequencer.sv
// hart_sequencer: multi-cycle control FSM of the hart
// (fetch -> decode -> execute -> memory -> writeback), owning PC and IR,
// arbitrating the single memory port and raising a sticky trap.
//   clk, rst_n    : clock, async active-low reset
//   bus           : memory port (master side)
//   ir            : instruction register, to decoder
//   opcode/funct3 : decoded fields from decoder
//   alu_result    : ALU output; effective address for loads/stores
//   pc            : program counter
//   operand_b_sel : 0 = rs2, 1 = immediate
//   wb_sel        : register write source
//   load_data     : raw latched load data
//   rf_we, retire : write strobe, per-instruction completion pulse
//   trap, trap_cause : sticky trap flag and cause
module hart_sequencer
    import isa_types::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hart_sequencer_if.master     bus,
    output logic [ILEN-1:0]      ir,
    input  opcode_t              opcode,
    input  logic [2:0]           funct3,
    input  logic [XLEN-1:0]      alu_result,
    output logic [XLEN-1:0]      pc,
    output logic                 operand_b_sel,
    output wb_sel_t              wb_sel,
    output logic [XLEN-1:0]      load_data,
    output logic                 rf_we,
    output logic                 retire,
    output logic                 trap,
    output trap_cause_t          trap_cause
);

    localparam logic [TIMEOUT_W-1:0] TimeoutLimit = TIMEOUT_W'(MEM_TIMEOUT);
    localparam logic [XLEN-1:0]      PcStep       = XLEN'(4);

    hart_state_t     state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    trap_cause_t     cause_q, cause_d;

    logic       req_active;
    logic       rf_we_raw;
    logic       retire_raw;
    logic       timed_out;
    logic       is_ls;
    logic [1:0] data_size;

    assign data_size = funct3[1:0];
    assign is_ls     = (opcode == OPCODE_LOAD) || (opcode == OPCODE_STORE);

    bus_timeout_counter #(
        .Width (TIMEOUT_W)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!bus.mem_req || bus.mem_ready),
        .en_i      (bus.mem_req && !bus.mem_ready),
        .limit_i   (TimeoutLimit),
        .expired_o (timed_out)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        addr_d        = addr_q;
        load_data_d   = load_data_q;
        cause_d       = cause_q;
        req_active    = 1'b0;
        rf_we_raw     = 1'b0;
        retire_raw    = 1'b0;
        bus.mem_addr  = pc_q;
        bus.mem_we    = 1'b0;
        bus.mem_size  = MEM_SIZE_W;
        operand_b_sel = (opcode == OPCODE_OP_IMM) || is_ls;

        case (opcode)
            OPCODE_LUI:  wb_sel = WB_UIMM;
            OPCODE_LOAD: wb_sel = WB_MEM;
            default:     wb_sel = WB_ALU;
        endcase

        case (state_q)
            StFetch: begin
                req_active = 1'b1;
                // Handshake takes priority over an expiry in the same cycle.
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata;
                    state_d = StDecode;
                end else if (timed_out) begin
                    cause_d = TRAP_TIMEOUT;
                    state_d = StTrap;
                end
            end

            StDecode: begin
                case (opcode)
                    OPCODE_LUI, OPCODE_OP, OPCODE_OP_IMM: state_d = StExecute;
                    OPCODE_LOAD:  state_d = load_funct3_ok(funct3) ? StExecute : StTrap;
                    OPCODE_STORE: state_d = store_funct3_ok(funct3) ? StExecute : StTrap;
                    default:      state_d = StTrap;
                endcase
                if (state_d == StTrap) begin
                    cause_d = TRAP_ILLEGAL;
                end
            end

            StExecute: begin
                if (is_ls) begin
                    addr_d = alu_result;
                    if (is_misaligned(data_size, alu_result[1:0])) begin
                        cause_d = TRAP_MISALIGNED;
                        state_d = StTrap;
                    end else begin
                        state_d = StMem;
                    end
                end else begin
                    state_d = StWriteback;
                end
            end

            StMem: begin
                req_active   = 1'b1;
                bus.mem_addr = addr_q;
                bus.mem_we   = (opcode == OPCODE_STORE);
                bus.mem_size = data_size;
                if (bus.mem_ready) begin
                    if (opcode == OPCODE_STORE) begin
                        retire_raw = 1'b1;
                        pc_d       = pc_q + PcStep;
                        state_d    = StFetch;
                    end else begin
                        load_data_d = bus.mem_rdata;
                        state_d     = StWriteback;
                    end
                end else if (timed_out) begin
                    cause_d = TRAP_TIMEOUT;
                    state_d = StTrap;
                end
            end

            StWriteback: begin
                rf_we_raw  = 1'b1;
                retire_raw = 1'b1;
                pc_d       = pc_q + PcStep;
                state_d    = StFetch;
            end

            StTrap: begin
                state_d = StTrap;
            end

            default: begin
                state_d = StTrap;
            end
        endcase

        // State resets to FETCH, so strobes are masked while reset is held.
        bus.mem_req = req_active && rst_n;
        rf_we       = rf_we_raw && rst_n;
        retire      = retire_raw && rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            addr_q      <= '0;
            load_data_q <= '0;
            cause_q     <= TRAP_NONE;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            addr_q      <= addr_d;
            load_data_q <= load_data_d;
            cause_q     <= cause_d;
        end
    end

    assign pc         = pc_q;
    assign ir         = ir_q;
    assign load_data  = load_data_q;
    assign trap_cause = cause_q;
    assign trap       = (state_q == StTrap);

endmodule
